// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared encodings for the multi-cycle sequencer and its decoder.
package instr_sequencer_pkg;
    localparam logic [1:0] PC_NORMAL   = 2'd0;
    localparam logic [1:0] PCSET_STEP  = 2'd1;
    localparam logic [1:0] PCSET_REF   = 2'd2;
    localparam logic [1:0] REGSRC_ALU  = 2'd0;
    localparam logic [1:0] REGSRC_LOAD = 2'd1;
    localparam logic [1:0] REGSRC_PC   = 2'd2;
    localparam logic       MEMSEL_PC   = 1'b0;
    localparam logic       MEMSEL_ALU  = 1'b1;
    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6,
        SEQ_FAULT  = 3'd7
    } seq_state_e;
endpackage

// File: rtl/instr_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged request cycles; expired flags the cycle that would reach TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end
    // an ack in the final cycle drops waiting, so the ack wins over expiry
    always_comb begin
        expired = (TIMEOUT != 0) && waiting && (cnt_q == W'(TIMEOUT - 1));
        cnt_d   = clear ? '0 : waiting ? cnt_q + W'(1) : cnt_q;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/DECODE/EXEC/MEM/WB control for the single-port datapath.
// Strobes are decoded from the state and the live decoder inputs; only state, wait count and retire count are registered.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic [1:0]       pcconfig,
    input  logic             ramconfig,
    input  logic             regbankconfig,
    input  logic [1:0]       regsource,
    input  logic             branch_cond,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             in_fetch, in_mem, in_wb;
    logic             waiting, expired, tmr_clear;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:   state_d = run ? SEQ_FETCH : SEQ_IDLE;
            SEQ_FETCH:  state_d = mem_ack ? SEQ_DECODE : expired ? SEQ_FAULT : SEQ_FETCH;
            SEQ_DECODE: state_d = halt_req ? SEQ_HALT : SEQ_EXEC;
            SEQ_EXEC:   state_d = (ramconfig || regsource == REGSRC_LOAD) ? SEQ_MEM : SEQ_WB;
            SEQ_MEM:    state_d = !mem_ack ? (expired ? SEQ_FAULT : SEQ_MEM)
                                : !ramconfig ? SEQ_WB : run ? SEQ_FETCH : SEQ_IDLE;
            SEQ_WB:     state_d = run ? SEQ_FETCH : SEQ_IDLE;
            default:    state_d = state_q;
        endcase
    end
    // reset masks every strobe so a pending request is dropped in the reset cycle itself
    always_comb begin
        in_fetch     = !reset && state_q == SEQ_FETCH;
        in_mem       = !reset && state_q == SEQ_MEM;
        in_wb        = !reset && state_q == SEQ_WB;
        mem_req      = in_fetch || in_mem;
        mem_we       = in_mem && ramconfig;
        mem_addr_sel = in_mem ? MEMSEL_ALU : MEMSEL_PC;
        ir_load      = in_fetch && mem_ack;
        pc_load      = in_wb || (in_mem && mem_ack && ramconfig);
        pc_sel       = (!in_wb || (pcconfig == PCSET_STEP && !branch_cond)) ? PC_NORMAL : pcconfig;
        reg_we       = in_wb && regbankconfig;
        retired_d    = retired_q + CNT_W'(pc_load);
        waiting      = mem_req && !mem_ack;
        tmr_clear    = reset || mem_ack
                    || (state_d != state_q && (state_d == SEQ_FETCH || state_d == SEQ_MEM));
    end
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clear   (tmr_clear),
        .waiting (waiting),
        .expired (expired)
    );
    assign busy          = !(state_q inside {SEQ_IDLE, SEQ_HALT, SEQ_FAULT});
    assign halted        = state_q == SEQ_HALT;
    assign fault         = state_q == SEQ_FAULT;
    assign state         = state_q;
    assign retired_count = retired_q;
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the single-port datapath that is configured by the instruction decoder.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Generates the IR/PC/register-bank/RAM strobes from the decoder's pcconfig, ramconfig, regbankconfig and regsource outputs.
- Owns the shared memory handshake, a wait timeout, and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: maximum cycles mem_req may wait for mem_ack before FAULT. 0 disables the timeout.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  system clock. Rising edge only.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level. Start or continue execution.
- halt_req  in  1  decoder flag: current IR is a halt instruction. Sampled in DECODE.
- pcconfig  in  2  decoder PC mode: PC_NORMAL, PCSET_STEP or PCSET_REF.
- ramconfig  in  1  decoder: instruction is a store.
- regbankconfig  in  1  decoder: instruction writes the register bank.
- regsource  in  2  decoder: REGSRC_ALU, REGSRC_LOAD or REGSRC_PC.
- branch_cond  in  1  ALU compare result (bit 0) for branch instructions. Sampled in WB.
- mem_ack  in  1  memory completes the current request. May be high in the same cycle as mem_req.
- mem_req  out  1  memory request. Held high until ack.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_load  out  1  latch the instruction register.
- pc_load  out  1  update the PC this cycle.
- pc_sel  out  2  PC next-value select, using the pcconfig encoding.
- reg_we  out  1  register-bank write enable.
- busy  out  1  high when not in IDLE, HALT or FAULT.
- halted  out  1  sticky halt flag.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  current state, for debug.
- retired_count  out  CNT_W  number of retired instructions.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7. Only the state register, wait counter and retired_count are registered. All strobes are decoded combinationally from the state and the current inputs.
- Reset, which overrides everything including mid-handshake:
  - state=IDLE, retired_count=0, wait counter=0.
  - All strobes are 0; halted=0; fault=0.
  - Any outstanding memory request is abandoned with no retry.
- IDLE:
  - All strobes 0.
  - run=1 → FETCH; otherwise stay.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - When mem_ack=1: ir_load=1 in that cycle, then → DECODE.
- DECODE:
  - One cycle; decoder outputs settle from IR.
  - halt_req=1 → HALT (the instruction is not retired). Otherwise → EXEC.
- EXEC:
  - One cycle; ALU operates.
  - ramconfig=1 or regsource==REGSRC_LOAD → MEM. Otherwise → WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=ramconfig.
  - When mem_ack=1 and it is a store: pc_load=1, pc_sel=PC_NORMAL, retired_count increments (the store retires), then → FETCH if run=1, else IDLE.
  - When mem_ack=1 and it is a load: → WB.
- WB:
  - reg_we=regbankconfig; pc_load=1; retired_count increments.
  - pc_sel:
    - PC_NORMAL when pcconfig=PC_NORMAL.
    - PCSET_STEP when pcconfig=PCSET_STEP and branch_cond=1; PC_NORMAL when branch_cond=0.
    - PCSET_REF when pcconfig=PCSET_REF.
  - Next state: FETCH if run=1, else IDLE.
- Latency with zero-wait memory (ack in the same cycle as req): ALU, branch and jump instructions take 4 cycles; loads take 5; stores take 4. Each wait cycle adds 1.
- Wait timer:
  - Clears on entry to FETCH or MEM and on ack.
  - Increments on each cycle with mem_req=1 and mem_ack=0.
  - If it reaches TIMEOUT (TIMEOUT>0) without ack → FAULT.
  - An ack in the same cycle the count reaches TIMEOUT wins; no fault.
- HALT and FAULT are absorbing until reset:
  - All strobes are 0; run is ignored.
  - halted=1 in HALT; fault=1 in FAULT.
- mem_ack outside FETCH/MEM is ignored.
- run deasserted mid-instruction does not abort. The current instruction completes, then the sequencer returns to IDLE.
- retired_count wraps modulo 2^CNT_W without a flag.
- ir_load, pc_load and reg_we are never high in the same cycle as reset.

Decomposition:
- constants.v gains:
  - the state encodings (SEQ_IDLE through SEQ_FAULT);
  - the MEMSEL_PC and MEMSEL_ALU encodings.
- The existing PC_NORMAL, PCSET_STEP, PCSET_REF and REGSRC_* encodings are reused unchanged.
- One sub-module, mem_wait_timer:
  - inputs: clear, waiting;
  - output: expired;
  - parameter: TIMEOUT.

Test Plan:
- Reset, run=1, ack tied high, ALU instruction (pcconfig=PC_NORMAL, regbankconfig=1) → states 1,2,3,5. reg_we and pc_load are high in cycle 4; retired_count=1.
- Load (regsource=REGSRC_LOAD) with ack delayed 3 cycles in MEM → mem_addr_sel=1 and mem_we=0 for 4 cycles, then WB with reg_we=1. Total 8 cycles.
- Store (ramconfig=1) → mem_we=1 in MEM. Retires in MEM with reg_we never high; the next state is FETCH.
- Branch, pcconfig=PCSET_STEP: branch_cond=1 → pc_sel=PCSET_STEP; branch_cond=0 → pc_sel=PC_NORMAL.
- TIMEOUT=4, ack held low in FETCH → FAULT after 4 wait cycles; fault=1, busy=0. Reset → IDLE with fault=0.
- halt_req=1 in DECODE → HALT, halted=1, retired_count unchanged. Reset asserted during MEM → IDLE next cycle with all strobes 0.
